auth_initiator: RTL

AUTH_INITIATOR -- requirements
Module: auth_initiator

---
 rtl/usb_auth_pkg.sv | 55 +++++
 rtl/auth_initiator_if.sv | 29 ++
 rtl/auth_resp_timer.sv | 35 +++
 rtl/auth_initiator.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/usb_auth_pkg.sv
// rtl/usb_auth_pkg.sv - shared protocol constants, enums and message layout for the auth initiator/responder
package usb_auth_pkg;

  localparam int MSG_W   = 1000;
  localparam int NONCE_W = 256;

  localparam logic [7:0] PROTO_VER = 8'h01;

  localparam logic [7:0] MT_GET_DIGESTS = 8'h81;
  localparam logic [7:0] MT_GET_CERT    = 8'h82;
  localparam logic [7:0] MT_CHALLENGE   = 8'h83;
  localparam logic [7:0] MT_DIGESTS     = 8'h01;
  localparam logic [7:0] MT_CERT        = 8'h02;
  localparam logic [7:0] MT_CHAL_AUTH   = 8'h03;
  localparam logic [7:0] MT_ERROR       = 8'h7F;

  localparam int VER_LSB     = 0;
  localparam int TYPE_LSB    = 8;
  localparam int P1_LSB      = 16;
  localparam int P2_LSB      = 24;
  localparam int PAYLOAD_LSB = 32;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_TIMEOUT = 3'd1,
    ERR_RESP    = 3'd2,
    ERR_TYPE    = 3'd3
  } err_code_e;

  // SEND_x is always WAIT_x - 1 so a resend can step back one state
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_DIG  = 3'd1,
    ST_WAIT_DIG  = 3'd2,
    ST_SEND_CERT = 3'd3,
    ST_WAIT_CERT = 3'd4,
    ST_SEND_CHAL = 3'd5,
    ST_WAIT_CHAL = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  function automatic logic [MSG_W-1:0] build_req(input logic [7:0] mtype,
                                                 input logic [7:0] p1,
                                                 input logic [NONCE_W-1:0] payload);
    logic [MSG_W-1:0] m;
    m = '0;
    m[VER_LSB +: 8]           = PROTO_VER;
    m[TYPE_LSB +: 8]          = mtype;
    m[P1_LSB +: 8]            = p1;
    m[P2_LSB +: 8]            = 8'h00;
    m[PAYLOAD_LSB +: NONCE_W] = payload;
    return m;
  endfunction

endpackage

// File: rtl/auth_initiator_if.sv
// rtl/auth_initiator_if.sv - request/response handshake bundle between host/responder and the initiator
interface auth_initiator_if;
  import usb_auth_pkg::*;

  logic               start_in;
  logic [NONCE_W-1:0] nonce_in;
  logic               resp_req_in;
  logic [MSG_W-1:0]   auth_msg_resp_in;
  logic               resp_req_out;
  logic [MSG_W-1:0]   auth_msg_resp_out;
  logic               busy_out;
  logic               done_out;
  logic               auth_pass_out;
  logic [2:0]         err_code_out;
  logic [NONCE_W-1:0] digest_out;

  modport master (
    output start_in, nonce_in, resp_req_in, auth_msg_resp_in,
    input  resp_req_out, auth_msg_resp_out, busy_out, done_out,
           auth_pass_out, err_code_out, digest_out
  );

  modport slave (
    input  start_in, nonce_in, resp_req_in, auth_msg_resp_in,
    output resp_req_out, auth_msg_resp_out, busy_out, done_out,
           auth_pass_out, err_code_out, digest_out
  );

endinterface

// File: rtl/auth_resp_timer.sv
// rtl/auth_resp_timer.sv - saturating response timeout counter
module auth_resp_timer #(
  parameter int RESP_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(RESP_TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (enable_i && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  // Expiry looks at the incremented value so a resend lands RESP_TIMEOUT cycles after the previous one
  assign expired_o = enable_i && !clear_i && (count_d >= LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/auth_initiator.sv
// rtl/auth_initiator.sv - GET_DIGESTS / GET_CERTIFICATE / CHALLENGE authentication sequencer
module auth_initiator
  import usb_auth_pkg::*;
#(
  parameter int RESP_TIMEOUT = 1000,
  parameter int MAX_RETRIES  = 2,
  parameter int SLOT         = 0
) (
  input logic             clk,
  input logic             reset,
  auth_initiator_if.slave bus
);

  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);
  localparam logic [7:0]    SLOT_ID     = 8'(SLOT);

  state_e             state_q;
  logic [RW-1:0]      retries_q;
  logic [NONCE_W-1:0] nonce_q, digest_q;
  logic [MSG_W-1:0]   msg_q;
  logic               req_q, busy_q, done_q, pass_q;
  err_code_e          err_q;

  logic               tmr_clear, tmr_enable, tmr_expired;
  logic               in_wait, resp_ok, resp_is_err;
  logic [7:0]         exp_type, resp_type, resp_ver;
  logic               unused_resp_bits;

  assign resp_ver  = bus.auth_msg_resp_in[VER_LSB +: 8];
  assign resp_type = bus.auth_msg_resp_in[TYPE_LSB +: 8];
  assign unused_resp_bits = ^{bus.auth_msg_resp_in[MSG_W-1:PAYLOAD_LSB+NONCE_W],
                              bus.auth_msg_resp_in[PAYLOAD_LSB-1:P1_LSB]};

  always_comb begin
    exp_type = MT_DIGESTS;
    in_wait  = 1'b1;
    case (state_q)
      ST_WAIT_DIG:  exp_type = MT_DIGESTS;
      ST_WAIT_CERT: exp_type = MT_CERT;
      ST_WAIT_CHAL: exp_type = MT_CHAL_AUTH;
      default:      in_wait  = 1'b0;
    endcase
  end

  assign resp_is_err = (resp_type == MT_ERROR);
  assign resp_ok     = (resp_ver == PROTO_VER) && (resp_type == exp_type);
  assign tmr_clear   = (state_q == ST_SEND_DIG) || (state_q == ST_SEND_CERT) ||
                       (state_q == ST_SEND_CHAL);
  assign tmr_enable  = in_wait && !bus.resp_req_in;

  auth_resp_timer #(.RESP_TIMEOUT(RESP_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_enable),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      retries_q <= '0;
      nonce_q   <= '0;
      digest_q  <= '0;
      msg_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_in) begin
            state_q   <= ST_SEND_DIG;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            err_q     <= ERR_NONE;
            nonce_q   <= bus.nonce_in;
            retries_q <= '0;
            req_q     <= 1'b1;
            msg_q     <= build_req(MT_GET_DIGESTS, 8'h00, '0);
          end
        end
        ST_WAIT_DIG, ST_WAIT_CERT, ST_WAIT_CHAL: begin
          // A response arriving on the expiry cycle wins over the resend
          if (bus.resp_req_in) begin
            if (resp_ok) begin
              retries_q <= '0;
              case (state_q)
                ST_WAIT_DIG: begin
                  digest_q <= bus.auth_msg_resp_in[PAYLOAD_LSB +: NONCE_W];
                  state_q  <= ST_SEND_CERT;
                  req_q    <= 1'b1;
                  msg_q    <= build_req(MT_GET_CERT, SLOT_ID, '0);
                end
                ST_WAIT_CERT: begin
                  state_q <= ST_SEND_CHAL;
                  req_q   <= 1'b1;
                  msg_q   <= build_req(MT_CHALLENGE, SLOT_ID, nonce_q);
                end
                default: begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  pass_q  <= 1'b1;
                  err_q   <= ERR_NONE;
                end
              endcase
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b0;
              err_q   <= resp_is_err ? ERR_RESP : ERR_TYPE;
            end
          end else if (tmr_expired) begin
            if (retries_q < RETRY_LIMIT) begin
              // msg_q still holds this request, so only the strobe is reissued
              retries_q <= retries_q + 1'b1;
              state_q   <= state_e'(state_q - 3'd1);
              req_q     <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b0;
              err_q   <= ERR_TIMEOUT;
            end
          end
        end
        ST_SEND_DIG, ST_SEND_CERT, ST_SEND_CHAL: begin
          state_q <= state_e'(state_q + 3'd1);
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.resp_req_out      = req_q;
  assign bus.auth_msg_resp_out = msg_q;
  assign bus.busy_out          = busy_q;
  assign bus.done_out          = done_q;
  assign bus.auth_pass_out     = pass_q;
  assign bus.err_code_out      = err_q;
  assign bus.digest_out        = digest_q;

endmodule
